fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage directly upstream of the opcode decoder. Holds the program counter and issues one word read per cycle to a synchronous instruction memory with fixed 1-cycle read latency. Buffers returned words in a 2-entry queue and presents them to decode with a valid/ready handshake; `opcode` drives the control decoder directly. Supports branch redirect with squash of the in-flight and buffered words.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  read request this cycle; combinational.
- `imem_addr`  out  32  word address of the request; valid when `imem_req`=1.
- `imem_rdata`  in  32  read data for the request issued in the previous cycle.
- `redirect`  in  1  branch taken; flush and refetch from `redirect_pc`.
- `redirect_pc`  in  32  branch target; word aligned (bits [1:0] ignored, treated as 0).
- `instr_valid`  out  1  queue head holds a valid instruction.
- `instr_ready`  in  1  decode accepts head this cycle.
- `instr`  out  32  queue head instruction word.
- `instr_pc`  out  32  address of `instr`.
- `opcode`  out  6  `instr[31:26]`; feeds the control decoder.

## Operation
- State: `pc` (32), `inflight` (1, request issued last cycle, data arrives this cycle), `inflight_pc` (32), 2-entry FIFO of {word, pc}, `count` (0..2).
- Per cycle, define `deq = instr_valid & instr_ready & ~redirect` and `enq = inflight & ~redirect`.
- Issue rule: `imem_req = 1` when `redirect`=1, or when `count + inflight - deq < 2`; otherwise 0. This guarantees every returned word has a FIFO slot; no response is ever dropped except by redirect.
- `imem_addr = redirect ? {redirect_pc[31:2],2'b00} : pc`.
- On issue: `pc <= imem_addr + 4` (32-bit wrap: 32'hFFFF_FFFC + 4 = 0); `inflight <= 1`, `inflight_pc <= imem_addr`. No issue: `pc` holds, `inflight <= 0`.
- On `enq`: write {`imem_rdata`, `inflight_pc`} at FIFO tail.
- On `deq`: advance head. Simultaneous `enq` and `deq` at `count`=2 or `count`=1 is legal; `count` unchanged.
- On `redirect`: FIFO cleared (`count <= 0`), response arriving this cycle discarded, handshake ignored (no dequeue even if `instr_ready`=1), request to target issued this cycle.
- `instr`, `instr_pc`, `opcode` come from FIFO head; values are don't-care when `instr_valid`=0, but must be stable while `instr_valid`=1 and `instr_ready`=0.
- `instr_valid = (count != 0)`; no combinational bypass from `imem_rdata`.

## Timing
- Reset (async assert, sync-effective release): `pc`=RESET_PC, `inflight`=0, `count`=0, `instr_valid`=0, `imem_req`=0 while `rst`=1. `instr`/`instr_pc`/`opcode` reset to 0.
- Reset mid-operation: all in-flight and buffered words lost; after release the fetch restarts at RESET_PC.
- First cycle after release (C0): `imem_req`=1, `imem_addr`=RESET_PC. C1: data returns, enqueued. C2: `instr_valid`=1 with RESET_PC word. Fetch-to-decode latency is 2 cycles.
- Steady state with `instr_ready` held 1: one instruction per cycle, sequential PCs.
- Backpressure: with `instr_ready`=0, FIFO fills to 2 and `imem_req` drops to 0 within the cycle the third slot would be needed; on `instr_ready` returning to 1, issue resumes the same cycle (deq term), no bubbles beyond the 2-cycle memory pipeline.
- Redirect in cycle R: target word visible at `instr` in R+2; no pre-redirect word appears at `instr_valid` from R onward.
- `redirect` while `count`=0 and `inflight`=0: same behaviour, target issued in R.

## Test plan
- Reset release with RESET_PC=32'h0000_0100, memory word[a]=a, `instr_ready`=1 -> `instr_valid` first high 2 cycles after release, `instr_pc` sequence 0x100, 0x104, 0x108 on consecutive cycles, `opcode`=`instr[31:26]`.
- Hold `instr_ready`=0 for 10 cycles then release -> `count` saturates at 2, `imem_req`=0 while full, no instruction lost or duplicated; PCs continue 0x100.. contiguous.
- Assert `redirect`=1 with `redirect_pc`=32'h0000_0400 while FIFO full and a request in flight -> `imem_addr`=0x400 that cycle, `instr_valid`=0 next cycle, `instr_pc`=0x400 two cycles after redirect, followed by 0x404.
- `redirect_pc`=32'h0000_0403 -> fetch at 0x400.
- PC wrap: redirect to 32'hFFFF_FFFC with ready=1 -> `instr_pc` 0xFFFF_FFFC then 0x0000_0000.
- Assert `rst` asynchronously mid-stream (between edges, FIFO holding 2) -> `instr_valid` and `imem_req` drop immediately; after release, first `instr_pc`=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, one-word-per-cycle requests to a 1-cycle
// synchronous instruction memory, 2-entry buffer feeding decode, branch redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [5:0]  opcode
);

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } FetchEntry;

    logic [31:0] pc;
    logic [31:0] inflightPc;
    logic        inflight;
    logic [1:0]  count;
    logic        rdPtr;
    logic        wrPtr;
    FetchEntry   fifo [2];

    logic        deq;
    logic        enq;
    logic [2:0]  occupancy;

    // NOTE: every signal in this block gets its value on every path, so no latch is inferred.
    always_comb begin
        deq       = instr_valid & instr_ready & ~redirect;
        enq       = inflight & ~redirect;
        // Slots committed after this cycle: anything issued now will need one.
        occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, deq};
        imem_req  = ~rst & (redirect | (occupancy < 3'd2));
        imem_addr = redirect ? {redirect_pc[31:2], 2'b00} : pc;
    end

    assign instr_valid = (count != 2'd0);
    assign instr       = fifo[rdPtr].word;
    assign instr_pc    = fifo[rdPtr].pc;
    assign opcode      = instr[31:26];

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            inflight   <= 1'b0;
            inflightPc <= '0;
            count      <= '0;
            rdPtr      <= 1'b0;
            wrPtr      <= 1'b0;
            // NOTE: the two buffer entries are reset so the head outputs read zero out of reset.
            fifo[0]    <= '0;
            fifo[1]    <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                pc         <= imem_addr + 32'd4;
                inflightPc <= imem_addr;
            end

            if (redirect) begin
                // Buffered words and the response landing this cycle are squashed.
                count <= '0;
                rdPtr <= 1'b0;
                wrPtr <= 1'b0;
            end else begin
                if (enq) begin
                    fifo[wrPtr] <= '{word: imem_rdata, pc: inflightPc};
                    wrPtr       <= ~wrPtr;
                end
                if (deq) begin
                    rdPtr <= ~rdPtr;
                end
                count <= count + {1'b0, enq} - {1'b0, deq};
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle vector table for start-up and backpressure,
// hand sequences for redirect, PC wrap and async reset, and a PC-stream scoreboard.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [5:0]  opcode;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .opcode      (opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory word at address a holds a; idle cycles return a poison value.
    always @(posedge clk) imem_rdata <= imem_req ? imem_addr : 32'hBAD0_0BAD;

    int          nVec  = 0;
    int          nMiss = 0;
    logic [31:0] expQ[$];
    logic [31:0] sbExp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMiss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void startStream(input logic [31:0] start);
        expQ.delete();
        for (int i = 0; i < 64; i++) expQ.push_back(start + 32'(4 * i));
    endfunction

    task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
        @(negedge clk);
        instr_ready = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        #1;
    endtask

    // Every accepted instruction must be the next word of the expected stream.
    always @(negedge clk) begin
        #2;
        if (!rst && instr_valid && instr_ready && !redirect) begin
            if (expQ.size() == 0) begin
                nVec++;
                nMiss++;
                $display("FAIL sb_empty: accepted pc %h, expected nothing", instr_pc);
            end else begin
                sbExp = expQ.pop_front();
                check("sb_pc", instr_pc, sbExp);
                check("sb_instr", instr, sbExp);
                check("sb_opcode", 32'(opcode), 32'(sbExp[31:26]));
            end
        end
    end

    typedef struct {
        logic        rdy;
        logic        expReq;
        logic [31:0] expAddr;
        logic        expValid;
        logic        chkPc;
        logic [31:0] expPc;
    } Vector;

    Vector vecs[$];

    initial begin
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b1;

        // Start-up with ready high, then 10 stalled cycles, then resume.
        vecs.push_back('{1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 32'h108, 1'b1, 1'b1, 32'h100});
        vecs.push_back('{1'b1, 1'b1, 32'h10C, 1'b1, 1'b1, 32'h104});
        vecs.push_back('{1'b1, 1'b1, 32'h110, 1'b1, 1'b1, 32'h108});
        for (int i = 0; i < 10; i++) vecs.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10C});
        vecs.push_back('{1'b1, 1'b1, 32'h114, 1'b1, 1'b1, 32'h10C});
        vecs.push_back('{1'b1, 1'b1, 32'h118, 1'b1, 1'b1, 32'h110});
        vecs.push_back('{1'b1, 1'b1, 32'h11C, 1'b1, 1'b1, 32'h114});

        repeat (2) @(negedge clk);
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", instr_pc, 32'd0);
        check("rst_opcode", 32'(opcode), 32'd0);

        @(posedge clk);
        #2;
        rst = 1'b0;
        startStream(RST_PC);

        foreach (vecs[i]) begin
            step(vecs[i].rdy, 1'b0, 32'h0);
            check($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vecs[i].expReq));
            if (vecs[i].expReq) check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].expAddr);
            check($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vecs[i].expValid));
            if (vecs[i].chkPc) check($sformatf("vec%0d_pc", i), instr_pc, vecs[i].expPc);
        end

        // Fill the buffer, then redirect to 0x400 while it is full.
        step(1'b0, 1'b0, 32'h0);
        check("fill_req0", 32'(imem_req), 32'd0);
        step(1'b0, 1'b0, 32'h0);
        check("full_req", 32'(imem_req), 32'd0);
        check("full_pc", instr_pc, 32'h118);
        step(1'b0, 1'b1, 32'h0000_0400);
        startStream(32'h400);
        check("redir_req", 32'(imem_req), 32'd1);
        check("redir_addr", imem_addr, 32'h400);
        step(1'b1, 1'b0, 32'h0);
        check("redir_r1_valid", 32'(instr_valid), 32'd0);
        check("redir_r1_addr", imem_addr, 32'h404);
        step(1'b1, 1'b0, 32'h0);
        check("redir_r2_valid", 32'(instr_valid), 32'd1);
        check("redir_r2_pc", instr_pc, 32'h400);
        step(1'b1, 1'b0, 32'h0);
        check("redir_r3_pc", instr_pc, 32'h404);

        // Unaligned target in steady state, with a response in flight.
        step(1'b1, 1'b1, 32'h0000_0403);
        startStream(32'h400);
        check("unal_addr", imem_addr, 32'h400);
        step(1'b1, 1'b0, 32'h0);
        check("unal_r1_valid", 32'(instr_valid), 32'd0);
        step(1'b1, 1'b0, 32'h0);
        check("unal_r2_pc", instr_pc, 32'h400);

        // PC wrap at the top of the address space.
        step(1'b1, 1'b1, 32'hFFFF_FFFC);
        startStream(32'hFFFF_FFFC);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'h0);
        check("wrap_r1_addr", imem_addr, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        check("wrap_r2_pc", instr_pc, 32'hFFFF_FFFC);
        check("wrap_r2_opcode", 32'(opcode), 32'h3F);
        step(1'b1, 1'b0, 32'h0);
        check("wrap_r3_pc", instr_pc, 32'h0);

        // Asynchronous reset mid-cycle with the buffer holding two words.
        repeat (3) step(1'b0, 1'b0, 32'h0);
        check("areset_pre_valid", 32'(instr_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("areset_valid", 32'(instr_valid), 32'd0);
        check("areset_req", 32'(imem_req), 32'd0);
        check("areset_pc", instr_pc, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        startStream(RST_PC);
        step(1'b1, 1'b0, 32'h0);
        check("restart_c0_req", 32'(imem_req), 32'd1);
        check("restart_c0_addr", imem_addr, RST_PC);
        step(1'b1, 1'b0, 32'h0);
        check("restart_c1_valid", 32'(instr_valid), 32'd0);
        step(1'b1, 1'b0, 32'h0);
        check("restart_c2_valid", 32'(instr_valid), 32'd1);
        check("restart_c2_pc", instr_pc, RST_PC);

        // Redirect from an idle pipe: first cycle after reset release.
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        step(1'b1, 1'b1, 32'h0000_0803);
        startStream(32'h800);
        check("idle_redir_req", 32'(imem_req), 32'd1);
        check("idle_redir_addr", imem_addr, 32'h800);
        step(1'b1, 1'b0, 32'h0);
        check("idle_r1_valid", 32'(instr_valid), 32'd0);
        step(1'b1, 1'b0, 32'h0);
        check("idle_r2_pc", instr_pc, 32'h800);

        // Random backpressure: the scoreboard checks the stream stays contiguous.
        for (int i = 0; i < 40; i++) begin
            step(1'(($urandom_range(0, 2)) != 0), 1'b0, 32'h0);
            if (instr_valid && count_full()) check("rand_full_req", 32'(imem_req), 32'(instr_ready));
        end

        step(1'b0, 1'b0, 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

    // Buffer is full only when the DUT head has been stalled: two words held, none in flight.
    // Derived from the bench's own history of the last two cycles.
    logic       prevReq;
    logic       prevPrevReq;
    logic       prevAccept;
    always @(posedge clk) begin
        prevPrevReq <= prevReq;
        prevReq     <= imem_req;
        prevAccept  <= instr_valid & instr_ready & ~redirect;
    end

    function automatic logic count_full();
        // Previous cycle issued nothing and did not dequeue while the head stayed valid,
        // which the issue rule only allows when both slots are committed.
        return !prevReq && !prevAccept && prevPrevReq;
    endfunction

endmodule
